// File: rtl/fir_stream_master.sv
// Wishbone master that streams taps and x samples into the FIR slave and
// returns each y result on a valid/ready output stream.
module fir_stream_master #(
   parameter int unsigned TAP_NUM     = 11,
   parameter int unsigned DATA_NUM    = 11,
   parameter logic [31:0] FIR_X_ADDR  = 32'h3820_0000,
   parameter logic [31:0] FIR_Y_ADDR  = 32'h3820_0010,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   input  logic        s_valid_i,
   input  logic [31:0] s_data_i,
   output logic        s_ready_o,
   output logic        m_valid_o,
   output logic [31:0] m_data_o,
   output logic        m_last_o,
   input  logic        m_ready_i,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        fir_ready_i,
   input  logic        fir_done_i
);

   localparam int unsigned TW = $clog2(TAP_NUM + 1);
   localparam int unsigned XW = $clog2(DATA_NUM + 1);
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TAP_LAST = TW'(TAP_NUM);
   localparam logic [XW-1:0] X_LAST   = XW'(DATA_NUM);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_IN, S_WR, S_WAIT_Y, S_RD, S_PUSH
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tap_cnt_q, tap_cnt_d;
   logic [XW-1:0] x_cnt_q, x_cnt_d;
   logic [CW-1:0] tmo_q, tmo_d;
   logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic          m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic [31:0]   m_data_q, m_data_d;
   logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [31:0]   adr_q, adr_d, dat_q, dat_d;
   logic          tmo_run, tmo_hit;

   assign s_ready_o = (state_q == S_WAIT_IN) & fir_ready_i;
   assign wbm_sel_o = 4'hF;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign m_valid_o = m_valid_q;
   assign m_data_o  = m_data_q;
   assign m_last_o  = m_last_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = stb_q;
   assign wbm_we_o  = we_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;

   always_comb begin
      state_d   = state_q;
      tap_cnt_d = tap_cnt_q;
      x_cnt_d   = x_cnt_q;
      done_d    = 1'b0;
      err_d     = err_q;
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      tmo_run   = 1'b0;
      tmo_hit   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A start coinciding with the done pulse belongs to the finished run.
            if (start_i && !done_q) begin
               state_d   = S_WAIT_IN;
               err_d     = 1'b0;
               tap_cnt_d = '0;
               x_cnt_d   = '0;
            end
         end
         S_WAIT_IN: begin
            tmo_run = s_valid_i & ~fir_ready_i;
            if (s_valid_i && s_ready_o) begin
               dat_d   = s_data_i;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = 1'b1;
               adr_d   = FIR_X_ADDR;
               state_d = S_WR;
            end
         end
         S_WR: begin
            tmo_run = 1'b1;
            if (wbm_ack_i) begin
               cyc_d = 1'b0;
               stb_d = 1'b0;
               we_d  = 1'b0;
               if (tap_cnt_q < TAP_LAST) begin
                  tap_cnt_d = tap_cnt_q + TW'(1);
                  state_d   = S_WAIT_IN;
               end else begin
                  x_cnt_d = x_cnt_q + XW'(1);
                  state_d = S_WAIT_Y;
               end
            end
         end
         S_WAIT_Y: begin
            tmo_run = 1'b1;
            if (fir_done_i) begin
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = 1'b0;
               adr_d   = FIR_Y_ADDR;
               state_d = S_RD;
            end
         end
         S_RD: begin
            tmo_run = 1'b1;
            if (wbm_ack_i) begin
               m_data_d  = wbm_dat_i;
               m_valid_d = 1'b1;
               m_last_d  = (x_cnt_q == X_LAST);
               cyc_d     = 1'b0;
               stb_d     = 1'b0;
               state_d   = S_PUSH;
            end
         end
         S_PUSH: begin
            if (m_ready_i) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (x_cnt_q == X_LAST) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT_IN;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Timeout only applies when no ack arrived this cycle, so an ack always wins.
      if (tmo_run && (tmo_q == TMO_LAST) && (state_d == state_q)) begin
         tmo_hit   = 1'b1;
         err_d     = 1'b1;
         cyc_d     = 1'b0;
         stb_d     = 1'b0;
         we_d      = 1'b0;
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
         state_d   = S_IDLE;
      end

      if (state_d != state_q || tmo_hit) tmo_d = '0;
      else if (tmo_run)                  tmo_d = tmo_q + CW'(1);
      else                               tmo_d = tmo_q;

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= S_IDLE;
         tap_cnt_q <= '0;
         x_cnt_q   <= '0;
         tmo_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
      end else begin
         state_q   <= state_d;
         tap_cnt_q <= tap_cnt_d;
         x_cnt_q   <= x_cnt_d;
         tmo_q     <= tmo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         m_data_q  <= m_data_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
      end
   end

endmodule
